// File: rtl/cpu_defs.sv
// Shared CPU definitions for the P7 core: exception codes, fetch address map
// and the NOP encoding used when a fetched word is squashed.
package cpu_defs;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6ffc;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  // TEXT_HI is the last legal word address, so the upper bound is inclusive.
  function automatic logic fetch_addr_fault(input logic [31:0] addr,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: redirect controls from ID/CP0, instruction-memory port and
// the IF-side values captured by the IF/ID register.
interface if_fetch_unit_if;
  logic        enable;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_is_jump;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_instr;
  logic [4:0]  IF_ExcCode;
  logic        IF_BD;
  logic [31:0] fetch_cnt;

  modport master (
    input  enable, req, eret, epc, branch_taken, branch_target, id_is_jump,
    input  imem_rdata,
    output imem_addr, IF_PC, IF_instr, IF_ExcCode, IF_BD, fetch_cnt
  );

  modport slave (
    output enable, req, eret, epc, branch_taken, branch_target, id_is_jump,
    output imem_rdata,
    input  imem_addr, IF_PC, IF_instr, IF_ExcCode, IF_BD, fetch_cnt
  );
endinterface

// File: rtl/npc_mux.sv
// Next-PC select. An accepted exception overrides a stall; a stall overrides
// eret, which in turn overrides an ID-stage branch.
module npc_mux #(
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC
) (
  input  logic [31:0] pc,
  input  logic        enable,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc + 32'd4;
    if (req)               npc = HANDLER_PC;
    else if (!enable)      npc = pc;
    else if (eret)         npc = epc;
    else if (branch_taken) npc = branch_target;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch qualification and fetch counter.
// Define IF_ADDR_CHECK_EN to enable AdEL generation on misaligned/out-of-text fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
  parameter logic [31:0] TEXT_LO    = cpu_defs::TEXT_LO,
  parameter logic [31:0] TEXT_HI    = cpu_defs::TEXT_HI
) (
  input logic               clk,
  input logic               reset,
  if_fetch_unit_if.master   bus
);
  import cpu_defs::*;

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] cnt;

  npc_mux #(
    .HANDLER_PC (HANDLER_PC)
  ) u_npc_mux (
    .pc            (pc),
    .enable        (bus.enable),
    .req           (bus.req),
    .eret          (bus.eret),
    .epc           (bus.epc),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .npc           (npc)
  );

  // A cycle that takes an exception does not retire its fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      cnt <= '0;
    end else begin
      pc <= npc;
      if (bus.enable && !bus.req) cnt <= cnt + 32'd1;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.IF_PC     = pc;
  assign bus.fetch_cnt = cnt;
  assign bus.IF_BD     = bus.id_is_jump & ~bus.eret;

`ifdef IF_ADDR_CHECK_EN
  logic adel;

  assign adel = fetch_addr_fault(pc, TEXT_LO, TEXT_HI);

  // The word behind an eret is squashed entirely, including any fault it carries.
  assign bus.IF_ExcCode = (adel && !bus.eret) ? EXC_ADEL : EXC_NONE;
  assign bus.IF_instr   = (adel || bus.eret) ? NOP_INSTR : bus.imem_rdata;
`else
  logic unused_text_range;

  assign unused_text_range = ^{TEXT_LO, TEXT_HI};
  assign bus.IF_ExcCode    = EXC_NONE;
  assign bus.IF_instr      = bus.imem_rdata;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the P7 pipelined MIPS core. Owns the program counter, drives the instruction-memory address, and qualifies the returned word. Produces the IF-side values (PC, instruction, exception code, delay-slot flag) that the IF/ID pipeline register captures. Resolves PC redirects from exception entry, `eret`, ID-stage branches/jumps and pipeline stalls.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `HANDLER_PC`, 32'h0000_4180: exception/interrupt handler entry.
- `TEXT_LO`, 32'h0000_3000: lowest legal fetch address.
- `TEXT_HI`, 32'h0000_6ffc: highest legal fetch address, inclusive.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = pipeline advances; 0 = stall, hold PC.
- `req` in 1: exception/interrupt accepted by CP0; redirect to handler.
- `eret` in 1: `eret` resolved in ID; redirect to `epc`.
- `epc` in 32: return address from CP0, already forwarded.
- `branch_taken` in 1: ID-stage branch/jump taken.
- `branch_target` in 32: ID-stage target address.
- `id_is_jump` in 1: ID-stage instruction is a branch/jump, taken or not.
- `imem_addr` out 32: instruction-memory word address (= PC).
- `imem_rdata` in 32: instruction word, combinational read.
- `IF_PC` out 32: current fetch PC.
- `IF_instr` out 32: qualified instruction.
- `IF_ExcCode` out 5: fetch exception code.
- `IF_BD` out 1: current fetch is a delay-slot instruction.
- `fetch_cnt` out 32: count of fetches that left IF.

## Operation
- PC register next-value priority, highest first:
  - `req` → `HANDLER_PC`. Applies even when `enable`=0.
  - `enable`=0 → hold.
  - `eret` → `epc`.
  - `branch_taken` → `branch_target`.
  - Otherwise → PC+4, mod 2^32.
- The instruction in IF while a branch is in ID is the delay slot: it is not nullified.
- The instruction in IF while `eret` is in ID is nullified: `IF_instr`=0, `IF_ExcCode`=0, `IF_BD`=0.
- Address check: AdEL (5'd4) when `PC[1:0]`≠0, or PC<`TEXT_LO`, or PC>`TEXT_HI`; otherwise `IF_ExcCode`=0.
- `IF_ExcCode`≠0 forces `IF_instr`=0. `IF_PC` still reports the faulting PC, for EPC/BadVAddr.
- `IF_BD` = `id_is_jump` & ~`eret`.
- `fetch_cnt`: +1 on each edge with `enable`=1 and `req`=0; wraps 32'hffff_ffff→0.
- `req` together with `eret`/`branch_taken`: `req` wins; branch and `eret` are dropped.

## Timing
- Reset values:
  - PC = `RESET_PC`, so `imem_addr` = `IF_PC` = 32'h3000.
  - `IF_instr` = `imem_rdata` at 32'h3000.
  - `IF_ExcCode` = 0, `IF_BD` = 0, `fetch_cnt` = 0.
- Reset asserted mid-operation: PC and counter clear immediately, without waiting for an edge.
- PC updates on the rising edge. All IF_* outputs are combinational from PC and the inputs, so they are valid in the same cycle.
- Redirect latency: one edge. The target address appears on `imem_addr` in the cycle after `req`/`eret`/`branch_taken` is sampled high.
- Stall: PC and `fetch_cnt` unchanged for every cycle `enable`=0; outputs remain stable.
- `eret` to a misaligned `epc`: the next cycle shows AdEL with `IF_PC`=`epc`.

## Configuration
- `IF_ADDR_CHECK_EN` defined: range and alignment check as described; AdEL is generated.
- `IF_ADDR_CHECK_EN` undefined: `IF_ExcCode` is tied to 0 and `IF_instr` = `imem_rdata` unconditionally (reduced-area build for the no-exception test images).

## Structure
- Shared package `cpu_defs` holds:
  - exception codes (`EXC_ADEL`=5'd4, `EXC_NONE`=0);
  - `RESET_PC`, `HANDLER_PC`, `TEXT_LO`, `TEXT_HI`;
  - the NOP encoding.
- One sub-module, `npc_mux`: combinational next-PC priority select. The PC register, address check and counter stay in the top.

## Test plan
- Release reset, hold `enable`=1 for 3 cycles → `IF_PC` steps 3000, 3004, 3008, 300c; `fetch_cnt`=3.
- At PC 3010, pulse `branch_taken` with target 3100, `id_is_jump`=1 → `IF_BD`=1 in that cycle, instruction kept; next `IF_PC`=3100.
- At PC 3020, hold `enable`=0 for 2 cycles, with `req`=1 in the second → PC holds 3020, then becomes 4180; `fetch_cnt` unchanged.
- With `eret`=1 and `epc`=3002 → in the `eret` cycle `IF_instr`=0 and `IF_BD`=0; next cycle `IF_PC`=3002, `IF_ExcCode`=4, `IF_instr`=0.
- Branch to 7000 → `IF_ExcCode`=4. With `IF_ADDR_CHECK_EN` undefined, the same stimulus gives `IF_ExcCode`=0 and passes `imem_rdata` through.
- Drop `reset` asynchronously mid-cycle at PC 3400 → PC is 3000 and `fetch_cnt` is 0 before the next edge.
